memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter that shares the single `memory` instance between the instruction-fetch port and the load/store data port, in preparation for the unified memory. Each port issues requests with a valid/ready handshake, and the arbiter grants at most one per cycle using round-robin on conflict. The granted request is registered into an access stage that drives the memory. The result is returned on a per-port response bus two cycles after acceptance, giving one access per cycle sustained.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: byte-address width.
- `DATA_WIDTH`, default 32: word width. Only 32 is supported.

Ports:
- `i_Clock`  in  1  single clock. All state updates on the rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_FetchReqValid`  in  1  fetch read request.
- `o_FetchReqReady`  out  1  fetch request accepted this cycle.
- `i_FetchAddress`  in  ADDR_WIDTH  fetch byte address.
- `o_FetchRspValid`  out  1  one-cycle pulse: fetch response present.
- `o_FetchRspData`  out  DATA_WIDTH  instruction word.
- `o_FetchRspError`  out  1  misaligned fetch.
- `i_DataReqValid`  in  1  load/store request.
- `o_DataReqReady`  out  1  data request accepted this cycle.
- `i_DataAddress`  in  ADDR_WIDTH  load/store byte address.
- `i_DataWriteEnable`  in  1  1 = store, 0 = load.
- `i_DataWriteData`  in  DATA_WIDTH  store data.
- `o_DataRspValid`  out  1  one-cycle pulse: data response present (loads and stores).
- `o_DataRspData`  out  DATA_WIDTH  load data. 0 for stores and errors.
- `o_DataRspError`  out  1  misaligned load/store.
- `o_MemWriteEnable`  out  1  to memory `i_WriteEnable`.
- `o_MemAddress`  out  ADDR_WIDTH  to memory `i_Address`.
- `o_MemDataIn`  out  DATA_WIDTH  to memory `i_DataIn`.
- `i_MemDataOut`  in  DATA_WIDTH  from memory `o_DataOut`. Combinational read of `o_MemAddress`.

## Operation

**Arbitration** is combinational from the valids and `r_LastGrant` (0 = fetch, 1 = data):
- Only one port valid: that port is granted.
- Both valid: the port not in `r_LastGrant` is granted.
- Neither valid: no grant.
- `o_*ReqReady` is high only for the granted port.
- Both readys are 0 while `i_Reset` is high.
- `r_LastGrant` updates only on an accepted request (valid & ready).

**Acceptance** (valid & ready at an edge) loads the access stage:
- Fields loaded: `r_AccValid` = 1, port, address, write flag, write data.
- Error flag: `r_AccError = address[1:0] != 0`.
- A fetch always loads write flag 0.
- If nothing is accepted, `r_AccValid` is cleared.

**Memory drive**, from the access stage only:
- `o_MemAddress = r_AccAddress`.
- `o_MemDataIn = r_AccData`.
- `o_MemWriteEnable = r_AccValid & r_AccWrite & ~r_AccError`.
- Address and data hold their last value when idle.
- Errored accesses never write memory.

**Response stage** is loaded at the edge that ends the access cycle:
- The owning port's `RspValid` is set to 1 and the other port's to 0.
- Data = `i_MemDataOut` for an error-free read, else 0.
- Error = `r_AccError`.
- If `r_AccValid` = 0, both `RspValid` are 0 and data/error hold.

Address bits above [17:2] pass through unchecked; the memory ignores them.

Responses have no backpressure. Requesters must accept the response in its valid cycle.

**Reset** (asynchronous, any time):
- All of the following go to 0: `r_AccValid`, `r_LastGrant` (so data wins the first conflict), all `o_*RspValid/Data/Error`, `o_MemWriteEnable`, `o_MemAddress`, `o_MemDataIn`.
- In-flight accesses and responses are dropped without a response.
- A store in the access stage is cancelled if reset asserts before its edge.

## Timing

- Request accepted at edge E0.
- Memory accessed during the cycle after E0. A store is written at edge E1.
- Response valid for exactly one cycle after E1.
- Latency is 2 edges.
- Throughput is one accepted request per cycle across both ports.
- Read-after-write: a load accepted at E1, right after a store accepted at E0 to the same word, returns the stored data, because the write commits at E1 and the read happens in the cycle after E1.
- Under continuous contention, grants alternate: data, fetch, data, fetch, ...
- Responses return in acceptance order. At most one response pulse is active per cycle.
- Request inputs are sampled only in the accepting cycle. A requester holds valid and payload until ready.

## Test plan

- Single fetch: memory word 0x10 = 0xDEADBEEF; fetch valid at address 0x40 -> ready the same cycle, `o_FetchRspValid` = 1 two cycles later with data 0xDEADBEEF and error 0; data port idle throughout.
- Contention: both ports valid continuously for 8 cycles after reset -> grants D, F, D, F, D, F, D, F; 4 responses per port, each 2 cycles after its grant; no cycle with both `RspValid` high.
- Read-after-write: store 0x12345678 to address 0x100, then load 0x100 on the next cycle -> store response with data 0, then load response with data 0x12345678 the following cycle.
- Misaligned: store to address 0x102 -> `o_DataRspError` = 1, `o_MemWriteEnable` never high, word 0x40 unchanged; fetch at address 0x3 -> `o_FetchRspError` = 1, data 0.
- Reset mid-flight: load accepted at E0, `i_Reset` pulsed between E0 and E1 -> no response ever appears, all outputs read 0, and the next contended request is granted to data.
- Idle/hold: no requests for 5 cycles -> `o_MemWriteEnable` = 0, no `RspValid`, readys low, `r_LastGrant` unchanged.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Request/response bus between the two requesters (fetch and load/store),
// the arbiter, and the shared memory. The arbiter connects through the slave
// modport. The requesters and the memory connect through the master modport.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Fetch port
    logic                  i_FetchReqValid;
    logic                  o_FetchReqReady;
    logic [ADDR_WIDTH-1:0] i_FetchAddress;
    logic                  o_FetchRspValid;
    logic [DATA_WIDTH-1:0] o_FetchRspData;
    logic                  o_FetchRspError;

    // Load/store port
    logic                  i_DataReqValid;
    logic                  o_DataReqReady;
    logic [ADDR_WIDTH-1:0] i_DataAddress;
    logic                  i_DataWriteEnable;
    logic [DATA_WIDTH-1:0] i_DataWriteData;
    logic                  o_DataRspValid;
    logic [DATA_WIDTH-1:0] o_DataRspData;
    logic                  o_DataRspError;

    // Shared memory side
    logic                  o_MemWriteEnable;
    logic [ADDR_WIDTH-1:0] o_MemAddress;
    logic [DATA_WIDTH-1:0] o_MemDataIn;
    logic [DATA_WIDTH-1:0] i_MemDataOut;

    modport slave (
        input  i_FetchReqValid, i_FetchAddress,
        output o_FetchReqReady, o_FetchRspValid, o_FetchRspData, o_FetchRspError,
        input  i_DataReqValid, i_DataAddress, i_DataWriteEnable, i_DataWriteData,
        output o_DataReqReady, o_DataRspValid, o_DataRspData, o_DataRspError,
        output o_MemWriteEnable, o_MemAddress, o_MemDataIn,
        input  i_MemDataOut
    );

    modport master (
        output i_FetchReqValid, i_FetchAddress,
        input  o_FetchReqReady, o_FetchRspValid, o_FetchRspData, o_FetchRspError,
        output i_DataReqValid, i_DataAddress, i_DataWriteEnable, i_DataWriteData,
        input  o_DataReqReady, o_DataRspValid, o_DataRspData, o_DataRspError,
        input  o_MemWriteEnable, o_MemAddress, o_MemDataIn,
        output i_MemDataOut
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single combinational-read memory.
// Pipeline: grant -> access stage (drives memory) -> response stage.
// One access per cycle, two-edge latency, responses in acceptance order.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    memory_arbiter_if.slave   bus
);
    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    logic                  w_FetchGrant;
    logic                  w_DataGrant;
    logic [DATA_WIDTH-1:0] w_ReadData;

    port_e                 r_LastGrant;
    logic                  r_AccValid;
    port_e                 r_AccPort;
    logic [ADDR_WIDTH-1:0] r_AccAddress;
    logic                  r_AccWrite;
    logic [DATA_WIDTH-1:0] r_AccData;
    logic                  r_AccError;

    logic                  r_FetchRspValid;
    logic [DATA_WIDTH-1:0] r_FetchRspData;
    logic                  r_FetchRspError;
    logic                  r_DataRspValid;
    logic [DATA_WIDTH-1:0] r_DataRspData;
    logic                  r_DataRspError;

    // Round-robin grant: a lone requester wins, on conflict the port that did not win last time wins.
    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch is inferred.
        w_FetchGrant = 1'b0;
        w_DataGrant  = 1'b0;
        // NOTE: grants are masked during reset so nothing is accepted while state is being cleared.
        if (!i_Reset) begin
            if (bus.i_FetchReqValid && (!bus.i_DataReqValid || r_LastGrant == PORT_DATA))
                w_FetchGrant = 1'b1;
            else if (bus.i_DataReqValid)
                w_DataGrant = 1'b1;
        end
    end

    // Stores and errored accesses return zero; only a clean read returns memory data.
    assign w_ReadData = (r_AccWrite || r_AccError) ? '0 : bus.i_MemDataOut;

    // Access stage: capture the accepted request, or go idle while holding address/data.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (i_Reset) begin
            r_LastGrant  <= PORT_FETCH;
            r_AccValid   <= 1'b0;
            r_AccPort    <= PORT_FETCH;
            r_AccAddress <= '0;
            r_AccWrite   <= 1'b0;
            r_AccData    <= '0;
            r_AccError   <= 1'b0;
        end else if (w_FetchGrant) begin
            r_LastGrant  <= PORT_FETCH;
            r_AccValid   <= 1'b1;
            r_AccPort    <= PORT_FETCH;
            r_AccAddress <= bus.i_FetchAddress;
            r_AccWrite   <= 1'b0;
            r_AccError   <= (bus.i_FetchAddress[1:0] != 2'b00);
        end else if (w_DataGrant) begin
            r_LastGrant  <= PORT_DATA;
            r_AccValid   <= 1'b1;
            r_AccPort    <= PORT_DATA;
            r_AccAddress <= bus.i_DataAddress;
            r_AccWrite   <= bus.i_DataWriteEnable;
            r_AccData    <= bus.i_DataWriteData;
            r_AccError   <= (bus.i_DataAddress[1:0] != 2'b00);
        end else begin
            r_AccValid   <= 1'b0;
        end
    end

    // Response stage: pulse the owning port's valid for one cycle with the access result.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_FetchRspValid <= 1'b0;
            r_FetchRspData  <= '0;
            r_FetchRspError <= 1'b0;
            r_DataRspValid  <= 1'b0;
            r_DataRspData   <= '0;
            r_DataRspError  <= 1'b0;
        end else if (r_AccValid) begin
            r_FetchRspValid <= (r_AccPort == PORT_FETCH);
            r_DataRspValid  <= (r_AccPort == PORT_DATA);
            if (r_AccPort == PORT_FETCH) begin
                r_FetchRspData  <= w_ReadData;
                r_FetchRspError <= r_AccError;
            end else begin
                r_DataRspData   <= w_ReadData;
                r_DataRspError  <= r_AccError;
            end
        end else begin
            r_FetchRspValid <= 1'b0;
            r_DataRspValid  <= 1'b0;
        end
    end

    assign bus.o_FetchReqReady  = w_FetchGrant;
    assign bus.o_DataReqReady   = w_DataGrant;

    assign bus.o_MemAddress     = r_AccAddress;
    assign bus.o_MemDataIn      = r_AccData;
    assign bus.o_MemWriteEnable = r_AccValid & r_AccWrite & ~r_AccError;

    assign bus.o_FetchRspValid  = r_FetchRspValid;
    assign bus.o_FetchRspData   = r_FetchRspData;
    assign bus.o_FetchRspError  = r_FetchRspError;
    assign bus.o_DataRspValid   = r_DataRspValid;
    assign bus.o_DataRspData    = r_DataRspData;
    assign bus.o_DataRspError   = r_DataRspError;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural combinational-read memory.
module tb_memory_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   wen_count;
    logic [31:0] mem [0:1023];

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge.
    assign bus.i_MemDataOut = mem[bus.o_MemAddress[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]     = 32'h1111_1111;
        mem[10'h10] = 32'hDEAD_BEEF;
        mem[10'h20] = 32'hCAFE_F00D;
        wen_count  = 0;
        forever begin
            @(posedge clk);
            if (bus.o_MemWriteEnable === 1'b1) begin
                mem[bus.o_MemAddress[11:2]] <= bus.o_MemDataIn;
                wen_count++;
            end
        end
    end

    task automatic idle_inputs();
        bus.i_FetchReqValid   = 1'b0;
        bus.i_FetchAddress    = 32'h0;
        bus.i_DataReqValid    = 1'b0;
        bus.i_DataAddress     = 32'h0;
        bus.i_DataWriteEnable = 1'b0;
        bus.i_DataWriteData   = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.i_FetchReqValid = 1'b1;
        bus.i_DataReqValid  = 1'b1;
        #3;
        total++;
        if ({bus.o_FetchReqReady, bus.o_DataReqReady} !== 2'b00) begin
            bad++;
            $display("FAIL reset_readys: got %b expected 00", {bus.o_FetchReqReady, bus.o_DataReqReady});
        end
        total++;
        if ({bus.o_FetchRspValid, bus.o_DataRspValid, bus.o_FetchRspError, bus.o_DataRspError, bus.o_MemWriteEnable} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.o_FetchRspValid, bus.o_DataRspValid, bus.o_FetchRspError, bus.o_DataRspError, bus.o_MemWriteEnable});
        end
        total++;
        if ({bus.o_FetchRspData, bus.o_DataRspData, bus.o_MemAddress, bus.o_MemDataIn} !== 128'h0) begin
            bad++;
            $display("FAIL reset_buses: got %h %h %h %h expected all zero",
                     bus.o_FetchRspData, bus.o_DataRspData, bus.o_MemAddress, bus.o_MemDataIn);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        bus.i_FetchReqValid = 1'b1;
        bus.i_FetchAddress  = 32'h40;
        #1;
        total++;
        if ({bus.o_FetchReqReady, bus.o_DataReqReady} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_ready: got %b expected 10", {bus.o_FetchReqReady, bus.o_DataReqReady});
        end
        @(posedge clk); #1;
        bus.i_FetchReqValid = 1'b0;
        total++;
        if (bus.o_FetchRspValid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_early_rsp: got %b expected 0", bus.o_FetchRspValid);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.o_FetchRspValid, bus.o_FetchRspData, bus.o_FetchRspError, bus.o_DataRspValid} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_rsp: got v=%b d=%h e=%b dv=%b expected v=1 d=deadbeef e=0 dv=0",
                     bus.o_FetchRspValid, bus.o_FetchRspData, bus.o_FetchRspError, bus.o_DataRspValid);
        end
        @(posedge clk); #1;
        total++;
        if (bus.o_FetchRspValid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_pulse: got %b expected 0", bus.o_FetchRspValid);
        end
    endtask

    task automatic test_contention();
        int  n_fetch;
        int  n_data;
        logic exp_d;
        n_fetch = 0;
        n_data  = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.i_FetchReqValid = 1'b1;
                bus.i_FetchAddress  = 32'h40;
                bus.i_DataReqValid  = 1'b1;
                bus.i_DataAddress   = 32'h80;
            end
            if (i == 8) idle_inputs();
            #1;
            if (i < 8) begin
                exp_d = (i % 2 == 0);
                total++;
                if ({bus.o_FetchReqReady, bus.o_DataReqReady} !== {~exp_d, exp_d}) begin
                    bad++;
                    $display("FAIL contention_grant[%0d]: got %b expected %b", i,
                             {bus.o_FetchReqReady, bus.o_DataReqReady}, {~exp_d, exp_d});
                end
            end
            @(posedge clk); #1;
            if (bus.o_FetchRspValid === 1'b1) n_fetch++;
            if (bus.o_DataRspValid === 1'b1) n_data++;
            if (i >= 1 && i <= 8) begin
                exp_d = ((i - 1) % 2 == 0);
                total++;
                if ({bus.o_FetchRspValid, bus.o_DataRspValid} !== {~exp_d, exp_d}) begin
                    bad++;
                    $display("FAIL contention_rsp[%0d]: got %b expected %b", i,
                             {bus.o_FetchRspValid, bus.o_DataRspValid}, {~exp_d, exp_d});
                end
                total++;
                if (exp_d && bus.o_DataRspData !== 32'hCAFE_F00D) begin
                    bad++;
                    $display("FAIL contention_ddata[%0d]: got %h expected cafef00d", i, bus.o_DataRspData);
                end else if (!exp_d && bus.o_FetchRspData !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL contention_fdata[%0d]: got %h expected deadbeef", i, bus.o_FetchRspData);
                end
            end else begin
                total++;
                if ({bus.o_FetchRspValid, bus.o_DataRspValid} !== 2'b00) begin
                    bad++;
                    $display("FAIL contention_quiet[%0d]: got %b expected 00", i,
                             {bus.o_FetchRspValid, bus.o_DataRspValid});
                end
            end
        end
        total++;
        if (n_fetch != 4 || n_data != 4) begin
            bad++;
            $display("FAIL contention_counts: got fetch=%0d data=%0d expected 4 and 4", n_fetch, n_data);
        end
    endtask

    task automatic test_read_after_write();
        @(negedge clk);
        bus.i_DataReqValid    = 1'b1;
        bus.i_DataAddress     = 32'h100;
        bus.i_DataWriteEnable = 1'b1;
        bus.i_DataWriteData   = 32'h1234_5678;
        #1;
        total++;
        if (bus.o_DataReqReady !== 1'b1) begin
            bad++;
            $display("FAIL raw_store_ready: got %b expected 1", bus.o_DataReqReady);
        end
        @(posedge clk); #1;
        bus.i_DataWriteEnable = 1'b0;
        bus.i_DataWriteData   = 32'h0;
        total++;
        if ({bus.o_DataReqReady, bus.o_MemWriteEnable} !== 2'b11) begin
            bad++;
            $display("FAIL raw_load_ready_we: got %b expected 11", {bus.o_DataReqReady, bus.o_MemWriteEnable});
        end
        @(posedge clk); #1;
        idle_inputs();
        total++;
        if ({bus.o_DataRspValid, bus.o_DataRspData, bus.o_DataRspError} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL raw_store_rsp: got v=%b d=%h e=%b expected v=1 d=00000000 e=0",
                     bus.o_DataRspValid, bus.o_DataRspData, bus.o_DataRspError);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.o_DataRspValid, bus.o_DataRspData, bus.o_DataRspError} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            bad++;
            $display("FAIL raw_load_rsp: got v=%b d=%h e=%b expected v=1 d=12345678 e=0",
                     bus.o_DataRspValid, bus.o_DataRspData, bus.o_DataRspError);
        end
        @(posedge clk); #1;
        total++;
        if (bus.o_DataRspValid !== 1'b0) begin
            bad++;
            $display("FAIL raw_pulse: got %b expected 0", bus.o_DataRspValid);
        end
    endtask

    task automatic test_misaligned();
        int wen_before;
        wen_before = wen_count;
        @(negedge clk);
        bus.i_DataReqValid    = 1'b1;
        bus.i_DataAddress     = 32'h102;
        bus.i_DataWriteEnable = 1'b1;
        bus.i_DataWriteData   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        idle_inputs();
        total++;
        if (bus.o_MemWriteEnable !== 1'b0) begin
            bad++;
            $display("FAIL misaligned_we: got %b expected 0", bus.o_MemWriteEnable);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.o_DataRspValid, bus.o_DataRspError, bus.o_DataRspData} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL misaligned_store_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=00000000",
                     bus.o_DataRspValid, bus.o_DataRspError, bus.o_DataRspData);
        end
        total++;
        if (wen_count != wen_before || mem[10'h40] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL misaligned_mem: got writes=%0d word=%h expected writes=0 word=12345678",
                     wen_count - wen_before, mem[10'h40]);
        end
        @(negedge clk);
        bus.i_FetchReqValid = 1'b1;
        bus.i_FetchAddress  = 32'h3;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        total++;
        if ({bus.o_FetchRspValid, bus.o_FetchRspError, bus.o_FetchRspData} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL misaligned_fetch_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=00000000",
                     bus.o_FetchRspValid, bus.o_FetchRspError, bus.o_FetchRspData);
        end
    endtask

    task automatic test_reset_midflight();
        int n_rsp;
        n_rsp = 0;
        @(negedge clk);
        bus.i_DataReqValid = 1'b1;
        bus.i_DataAddress  = 32'h80;
        @(posedge clk); #1;
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.o_FetchRspValid, bus.o_DataRspValid, bus.o_MemWriteEnable, bus.o_FetchRspError, bus.o_DataRspError} !== 5'b0 ||
            {bus.o_FetchRspData, bus.o_DataRspData, bus.o_MemAddress, bus.o_MemDataIn} !== 128'h0) begin
            bad++;
            $display("FAIL midflight_outputs: got flags=%b fd=%h dd=%h ma=%h md=%h expected all zero",
                     {bus.o_FetchRspValid, bus.o_DataRspValid, bus.o_MemWriteEnable, bus.o_FetchRspError, bus.o_DataRspError},
                     bus.o_FetchRspData, bus.o_DataRspData, bus.o_MemAddress, bus.o_MemDataIn);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.o_FetchRspValid !== 1'b0 || bus.o_DataRspValid !== 1'b0) n_rsp++;
        end
        total++;
        if (n_rsp != 0) begin
            bad++;
            $display("FAIL midflight_no_rsp: got %0d response cycles expected 0", n_rsp);
        end
        @(negedge clk);
        bus.i_FetchReqValid = 1'b1;
        bus.i_DataReqValid  = 1'b1;
        #1;
        total++;
        if ({bus.o_FetchReqReady, bus.o_DataReqReady} !== 2'b01) begin
            bad++;
            $display("FAIL midflight_first_grant: got %b expected 01", {bus.o_FetchReqReady, bus.o_DataReqReady});
        end
        idle_inputs();
    endtask

    task automatic test_idle();
        int n_bad_idle;
        n_bad_idle = 0;
        // Leave the data port as last winner, then drain.
        @(negedge clk);
        bus.i_DataReqValid = 1'b1;
        bus.i_DataAddress  = 32'h80;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({bus.o_MemWriteEnable, bus.o_FetchRspValid, bus.o_DataRspValid,
                 bus.o_FetchReqReady, bus.o_DataReqReady} !== 5'b0) n_bad_idle++;
        end
        total++;
        if (n_bad_idle != 0) begin
            bad++;
            $display("FAIL idle_quiet: got %0d non-quiet cycles expected 0", n_bad_idle);
        end
        bus.i_FetchReqValid = 1'b1;
        bus.i_DataReqValid  = 1'b1;
        #1;
        total++;
        if ({bus.o_FetchReqReady, bus.o_DataReqReady} !== 2'b10) begin
            bad++;
            $display("FAIL idle_lastgrant_held: got %b expected 10", {bus.o_FetchReqReady, bus.o_DataReqReady});
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_read_after_write();
        test_misaligned();
        test_reset_midflight();
        test_idle();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
